mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sits between the MEM pipeline stage and the data-side AXI/cache bridge (data_axi).
//  - Turns a one-cycle load/store op into a held mem_ren/mem_wen request.
//  - Aligns store data and byte strobes; sign/zero-extends load data.
//  - Raises a pipeline stall until the bridge responds.
//  - Survives a pipeline flush mid-transaction: an AXI access cannot be aborted, so it drains it.
// PARAMETERS
//  UNCACHED_SEG  3'b101  addr[31:29] value of the uncached segment (0xA000_0000-0xBFFF_FFFF)
//  AW            32      address width
//  DW            32      data width (only 32 supported)
// PORTS
//  clk            in   1   clock, rising edge
//  resetn         in   1   asynchronous active-low reset
//  flush          in   1   pipeline flush (exception/eret)
//  req_valid      in   1   MEM stage holds a load/store this cycle
//  req_we         in   1   1=store, 0=load
//  req_size       in   2   0=byte, 1=half, 2=word (3 reserved, treated as word)
//  req_sign       in   1   load sign-extend
//  req_addr       in   32  virtual data address
//  req_wdata      in   32  unaligned store data (LSBs significant)
//  ex_addr_i      in   32  EX-stage address, passed through for cache prefetch lookup
//  stall_req      out  1   hold MEM and earlier stages
//  load_valid     out  1   one-cycle pulse: load_data valid
//  load_data      out  32  extended load result
//  adel / ades    out  1   misaligned load / store (combinational, same cycle as req)
//  mem_ren/mem_wen  out 1  to bridge, held until response
//  mem_wsel       out  4   byte strobes
//  mem_addr/mem_wdata out 32  registered request address / aligned store data
//  cached_trans   out  1   addr[31:29]!=UNCACHED_SEG, registered with the request
//  ex_addr        out  32  = ex_addr_i
//  mem_rdata      in   32  ; mem_rvalid in 1 ; mem_bvalid in 1  (from bridge)
// BEHAVIOUR
//  Reset: state=IDLE; every registered output 0; stall_req=0, load_valid=0.
//  Misalignment check:
//   - word: addr[1:0]!=0; half: addr[0]!=0.
//   - Sets adel/ades; no request is issued; stall_req=0.
//  FSM states: IDLE, RD_WAIT, WR_WAIT, DONE, DRAIN.
//   IDLE:
//    - req_valid & aligned & !flush: latch addr/wdata/wsel/size/sign/cached.
//    - Go to RD_WAIT or WR_WAIT.
//    - stall_req=1 combinationally in the accept cycle.
//   RD_WAIT/WR_WAIT:
//    - mem_ren (resp. mem_wen) =1 and stable; stall_req=1.
//    - mem_rvalid (resp. mem_bvalid) -> DONE; capture the extended load.
//   DONE (1 cycle):
//    - mem_ren/wen=0, stall_req=0; load_valid=1 for loads.
//    - req_valid ignored: it is still the completed instruction. -> IDLE.
//   Flush:
//    - flush in *_WAIT -> DRAIN.
//    - Response in the same cycle as flush -> IDLE with load_valid suppressed.
//   DRAIN:
//    - mem_ren/wen held; no load_valid.
//    - stall_req = req_valid, so a new post-flush request waits.
//    - On response -> IDLE.
//   flush in DONE suppresses load_valid.
//  Store align:
//   - byte: wsel=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
//   - half: wsel=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
//   - word: 1111.
//  Load extend: select byte/half by latched addr[1:0]; extend by req_sign; word unchanged.
//  Latency: min 3 cycles accept->load_valid (accept, response cycle, DONE).
// STRUCTURE
//  - defines.v: size codes (SZ_B/SZ_H/SZ_W) and FSM state encodings; AXI_DATA_Id stays there.
//  - Sub-module mem_align (combinational): store wsel/wdata shift and load extend.
//  - FSM plus request registers live in the top level.
// TESTING
//  - lw 0x8000_0010, mem_rvalid after 4 cycles with 0xDEADBEEF -> stall 5 cycles;
//    load_valid once; load_data=0xDEADBEEF; cached_trans=1.
//  - lb sign addr 0xA000_0003, rdata 0x80FF_FF7F -> load_data=0xFFFF_FF80, cached_trans=0;
//    lbu -> 0x0000_0080.
//  - sh addr 0x..02 wdata 0x1234ABCD -> mem_wsel=1100, mem_wdata=0xABCDABCD;
//    mem_wen held until mem_bvalid.
//  - lw addr 0x..01 -> adel=1 same cycle; mem_ren never asserted; stall_req=0.
//  - flush 2 cycles into RD_WAIT, new lw presented -> mem_ren held until old rvalid;
//    no load_valid for the old load; new lw issued in the cycle after the rvalid.
//  - resetn low in WR_WAIT -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared size codes, FSM states and the alignment rule for the MEM-stage access controller.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  // Reserved size code 3 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Combinational data steering: store byte-lane replication/strobes and load lane select/extend.
module mem_access_ctrl_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wsel,
  output logic [31:0] st_wdata_al,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_sign,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wsel     = 4'b1111;
    st_wdata_al = st_wdata;
    case (st_size)
      SZ_B: begin
        st_wsel     = 4'b0001 << st_addr_lo;
        st_wdata_al = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_wsel     = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_al = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: holds requests to the data bridge, stalls the pipe,
// and drains an in-flight access that a flush cannot abort.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter logic [2:0] UNCACHED_SEG = 3'b101,
  parameter int         AW           = 32,
  parameter int         DW           = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_sign,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [AW-1:0] ex_addr_i,
  output logic          stall_req,
  output logic          load_valid,
  output logic [DW-1:0] load_data,
  output logic          adel,
  output logic          ades,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [3:0]    mem_wsel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cached_trans,
  output logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  input  logic          mem_bvalid
);

  state_t        state;
  logic [1:0]    size_q;
  logic          sign_q;
  logic          lv_q;
  logic          misaligned;
  logic          accept;
  logic          resp;
  logic [3:0]    st_wsel;
  logic [DW-1:0] st_wdata_al;
  logic [DW-1:0] ld_ext;

  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign adel       = req_valid & misaligned & ~req_we;
  assign ades       = req_valid & misaligned & req_we;
  assign accept     = (state == ST_IDLE) & req_valid & ~misaligned & ~flush;
  assign resp       = (mem_ren & mem_rvalid) | (mem_wen & mem_bvalid);
  assign ex_addr    = ex_addr_i;

  // A flush landing on the DONE cycle kills the load result of the squashed instruction.
  assign load_valid = lv_q & ~flush;

  mem_access_ctrl_align u_align (
    .st_size     (req_size),
    .st_addr_lo  (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .st_wsel     (st_wsel),
    .st_wdata_al (st_wdata_al),
    .ld_size     (size_q),
    .ld_addr_lo  (mem_addr[1:0]),
    .ld_sign     (sign_q),
    .ld_rdata    (mem_rdata),
    .ld_data     (ld_ext)
  );

  // While draining, only a new post-flush request has to wait.
  always_comb begin
    stall_req = 1'b0;
    case (state)
      ST_IDLE:    stall_req = accept;
      ST_RD_WAIT: stall_req = 1'b1;
      ST_WR_WAIT: stall_req = 1'b1;
      ST_DRAIN:   stall_req = req_valid;
      default:    stall_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      size_q       <= 2'd0;
      sign_q       <= 1'b0;
      lv_q         <= 1'b0;
      load_data    <= '0;
      mem_ren      <= 1'b0;
      mem_wen      <= 1'b0;
      mem_wsel     <= 4'b0000;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cached_trans <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_addr     <= req_addr;
            mem_wdata    <= st_wdata_al;
            mem_wsel     <= req_we ? st_wsel : 4'b0000;
            size_q       <= req_size;
            sign_q       <= req_sign;
            cached_trans <= req_addr[AW-1 -: 3] != UNCACHED_SEG;
            mem_ren      <= ~req_we;
            mem_wen      <= req_we;
            state        <= req_we ? ST_WR_WAIT : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (resp) begin
            mem_ren   <= 1'b0;
            load_data <= ld_ext;
            lv_q      <= ~flush;
            state     <= flush ? ST_IDLE : ST_DONE;
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_WR_WAIT: begin
          if (resp) begin
            mem_wen <= 1'b0;
            state   <= flush ? ST_IDLE : ST_DONE;
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          lv_q  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (resp) begin
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
